gshare_predictor: RTL and testbench

- Parametrised successor to the fetch-stage branch predictor.
- Global-history pattern history table (PHT) of 2-bit saturating counters.
- Separate speculative and committed history registers, with history recovery on flush.
- Predicts jal and b-type targets combinationally for IF; trains from EX-resolved b-types.

---
 rtl/gshare_predictor_if.sv | 39 +++
 rtl/gshare_predictor.sv | 136 +++++++++++++
 tb/tb_gshare_predictor.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_predictor_if.sv
// gshare_predictor_if
// Bundles the fetch-side prediction handshake and the EX-side training
// signals of the gshare branch predictor.
//   rdy               global ready, low freezes predictor state
//   if_valid/if_pc/inst            fetched instruction from IF
//   pred_jump_or_not/pred_pc/pred_hist   prediction back to IF
//   ex_valid/ex_btype/ex_taken/ex_pc/ex_hist   resolved branch from EX
//   failed            mispredict flush from EX
// Modports: master drives the pipeline side, slave is the predictor.
interface gshare_predictor_if #(
    parameter int ADDR_W = 32,
    parameter int HIST_W = 3
);
    logic              rdy;
    logic              if_valid;
    logic [ADDR_W-1:0] if_pc;
    logic [31:0]       inst;
    logic              pred_jump_or_not;
    logic [ADDR_W-1:0] pred_pc;
    logic [HIST_W-1:0] pred_hist;
    logic              ex_valid;
    logic              ex_btype;
    logic              ex_taken;
    logic [ADDR_W-1:0] ex_pc;
    logic [HIST_W-1:0] ex_hist;
    logic              failed;

    modport master (
        output rdy, if_valid, if_pc, inst,
        output ex_valid, ex_btype, ex_taken, ex_pc, ex_hist, failed,
        input  pred_jump_or_not, pred_pc, pred_hist
    );

    modport slave (
        input  rdy, if_valid, if_pc, inst,
        input  ex_valid, ex_btype, ex_taken, ex_pc, ex_hist, failed,
        output pred_jump_or_not, pred_pc, pred_hist
    );
endinterface

// File: rtl/gshare_predictor.sv
// gshare_predictor
// Global-history branch predictor for the fetch stage. A table of 2-bit
// saturating counters is indexed by PC bits combined with global history.
// jal and b-type targets are predicted combinationally; training comes from
// b-types resolved in EX. A speculative history is advanced at fetch and is
// rebuilt from the committed history on a mispredict flush.
// Ports:
//   clk  clock
//   rst  synchronous reset, active low
//   bus  gshare_predictor_if.slave (fetch request/prediction, EX training)
// Build option:
//   GSHARE_XOR_EN  index = pc[IDX_W+1:2] ^ zero-extended history
//                  (default: history concatenated above the PC bits)
module gshare_predictor #(
    parameter int          ADDR_W   = 32,
    parameter int          HIST_W   = 3,
    parameter int          IDX_W    = 7,
    parameter logic [1:0]  CTR_INIT = 2'b10
) (
    input  logic               clk,
    input  logic               rst,
    gshare_predictor_if.slave  bus
);

    localparam int PHT_N = 2 ** IDX_W;

    logic [1:0]        r_pht [PHT_N];
    logic [HIST_W-1:0] r_specHist;
    logic [HIST_W-1:0] r_comHist;

    logic              w_isJal;
    logic              w_isBr;
    logic [ADDR_W-1:0] w_immJ;
    logic [ADDR_W-1:0] w_immB;
    logic [IDX_W-1:0]  w_idxRd;
    logic [IDX_W-1:0]  w_idxWr;
    logic              w_brTaken;
    logic [1:0]        w_ctrWr;
    logic [1:0]        w_ctrNext;
    logic              w_exTrain;
    logic [HIST_W-1:0] w_comHistNext;
    logic              w_unusedExPc;

    // Only the PC bits that feed the index matter on the training side.
    assign w_unusedExPc = ^{bus.ex_pc[ADDR_W-1:IDX_W+2], bus.ex_pc[1:0]};

    function automatic logic [IDX_W-1:0] phtIdx(
        input logic [IDX_W-1:0]  pcBits,
        input logic [HIST_W-1:0] hist
    );
        logic [IDX_W-1:0] histExt;
        histExt = IDX_W'(hist);
`ifdef GSHARE_XOR_EN
        return pcBits ^ histExt;
`else
        // History occupies the top HIST_W bits; when HIST_W == IDX_W the
        // mask is zero and the index is the history alone.
        begin
            logic [IDX_W-1:0] lowMask;
            lowMask = (IDX_W'(1) << (IDX_W - HIST_W)) - IDX_W'(1);
            return (histExt << (IDX_W - HIST_W)) | (pcBits & lowMask);
        end
`endif
    endfunction

    assign w_isJal = (bus.inst[6:0] == 7'b1101111);
    assign w_isBr  = (bus.inst[6:0] == 7'b1100011);

    assign w_immJ = {{(ADDR_W-20){bus.inst[31]}}, bus.inst[19:12], bus.inst[20],
                     bus.inst[30:21], 1'b0};
    assign w_immB = {{(ADDR_W-12){bus.inst[31]}}, bus.inst[7], bus.inst[30:25],
                     bus.inst[11:8], 1'b0};

    assign w_idxRd   = phtIdx(bus.if_pc[IDX_W+1:2], r_specHist);
    assign w_brTaken = r_pht[w_idxRd][1];
    assign w_idxWr   = phtIdx(bus.ex_pc[IDX_W+1:2], bus.ex_hist);
    assign w_ctrWr   = r_pht[w_idxWr];
    assign w_exTrain = bus.ex_valid & bus.ex_btype;

    // Truncating the concatenation keeps the newest HIST_W outcomes, which
    // also covers HIST_W == 1.
    assign w_comHistNext = w_exTrain ? HIST_W'({r_comHist, bus.ex_taken}) : r_comHist;

    always_comb begin
        w_ctrNext = w_ctrWr;
        if (bus.ex_taken && w_ctrWr != 2'b11) begin
            w_ctrNext = w_ctrWr + 2'b01;
        end else if (!bus.ex_taken && w_ctrWr != 2'b00) begin
            w_ctrNext = w_ctrWr - 2'b01;
        end
    end

    // Prediction is suppressed during reset and on the flush cycle so IF
    // never redirects on a stale path.
    always_comb begin
        bus.pred_jump_or_not = 1'b0;
        bus.pred_pc          = '0;
        if (rst && !bus.failed) begin
            if (w_isJal) begin
                bus.pred_jump_or_not = 1'b1;
                bus.pred_pc          = bus.if_pc + w_immJ;
            end else if (w_isBr) begin
                bus.pred_jump_or_not = w_brTaken;
                bus.pred_pc          = w_brTaken ? (bus.if_pc + w_immB)
                                                 : (bus.if_pc + ADDR_W'(4));
            end else begin
                bus.pred_pc = bus.if_pc + ADDR_W'(4);
            end
        end
    end

    assign bus.pred_hist = r_specHist;

    // On a flush the speculative history restarts from the committed history
    // including the outcome resolved in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_specHist <= '0;
            r_comHist  <= '0;
            for (int i = 0; i < PHT_N; i++) begin
                r_pht[i] <= CTR_INIT;
            end
        end else if (bus.rdy) begin
            r_comHist <= w_comHistNext;
            if (bus.failed) begin
                r_specHist <= w_comHistNext;
            end else if (bus.if_valid && w_isBr) begin
                r_specHist <= HIST_W'({r_specHist, w_brTaken});
            end
            if (w_exTrain) begin
                r_pht[w_idxWr] <= w_ctrNext;
            end
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// tb_gshare_predictor
// Directed vectors for gshare_predictor. Each fetch pushes its expected
// prediction into a queue; a monitor pops and compares on every cycle the
// fetch side is valid.
module tb_gshare_predictor;

    localparam int ADDR_W = 32;
    localparam int HIST_W = 3;
    localparam logic [31:0] OTHER = 32'h00000013;

    typedef struct packed {
        logic              jump;
        logic [ADDR_W-1:0] pc;
        logic [HIST_W-1:0] hist;
    } exp_t;

    logic  clk;
    logic  rst;
    exp_t  expQ[$];
    string nameQ[$];
    int    checks = 0;
    int    errors = 0;

    gshare_predictor_if #(.ADDR_W(ADDR_W), .HIST_W(HIST_W)) bus ();

    gshare_predictor #(
        .ADDR_W(ADDR_W), .HIST_W(HIST_W), .IDX_W(7), .CTR_INIT(2'b10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encB(input int imm);
        logic [12:0] v;
        v = 13'(imm);
        return {v[12], v[10:5], 5'd2, 5'd1, 3'b000, v[4:1], v[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(input int imm);
        logic [20:0] v;
        v = 21'(imm);
        return {v[20], v[10:1], v[11], v[19:12], 5'd1, 7'b1101111};
    endfunction

    task automatic checkOutput();
        exp_t  e;
        string n;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard_underflow: got output, expected none");
            return;
        end
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checks++;
        if (bus.pred_jump_or_not !== e.jump) begin
            errors++;
            $display("[TB] FAIL %s.jump: got %0b expected %0b", n, bus.pred_jump_or_not, e.jump);
        end
        checks++;
        if (bus.pred_pc !== e.pc) begin
            errors++;
            $display("[TB] FAIL %s.pc: got %08h expected %08h", n, bus.pred_pc, e.pc);
        end
        checks++;
        if (bus.pred_hist !== e.hist) begin
            errors++;
            $display("[TB] FAIL %s.hist: got %03b expected %03b", n, bus.pred_hist, e.hist);
        end
    endtask

    always @(negedge clk) begin
        if (bus.if_valid === 1'b1) begin
            checkOutput();
        end
    end

    task automatic applyStimulus(
        input logic        ifV,
        input logic [31:0] pc,
        input logic [31:0] inst,
        input logic        exV,
        input logic        exB,
        input logic        exT,
        input logic [31:0] exPc,
        input logic [2:0]  exHist,
        input logic        fail,
        input logic        rdyIn,
        input logic        expJ,
        input logic [31:0] expPc,
        input logic [2:0]  expHist,
        input string       name
    );
        exp_t e;
        bus.if_valid = ifV;
        bus.if_pc    = pc;
        bus.inst     = inst;
        bus.ex_valid = exV;
        bus.ex_btype = exB;
        bus.ex_taken = exT;
        bus.ex_pc    = exPc;
        bus.ex_hist  = exHist;
        bus.failed   = fail;
        bus.rdy      = rdyIn;
        if (ifV) begin
            e.jump = expJ;
            e.pc   = expPc;
            e.hist = expHist;
            expQ.push_back(e);
            nameQ.push_back(name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst,
                         input logic expJ, input logic [31:0] expPc,
                         input logic [2:0] expHist, input string name);
        applyStimulus(1'b1, pc, inst, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1,
                      expJ, expPc, expHist, name);
    endtask

    task automatic exUpdate(input logic taken, input logic [31:0] exPc,
                            input logic [2:0] exHist, input logic fail);
        applyStimulus(1'b0, 32'h0, OTHER, 1'b1, 1'b1, taken, exPc, exHist, fail, 1'b1,
                      1'b0, 32'h0, 3'b000, "");
    endtask

    initial begin
        rst = 1'b0;
        bus.rdy = 1'b1;
        bus.if_valid = 1'b0;
        bus.if_pc = '0;
        bus.inst = OTHER;
        bus.ex_valid = 1'b0;
        bus.ex_btype = 1'b0;
        bus.ex_taken = 1'b0;
        bus.ex_pc = '0;
        bus.ex_hist = '0;
        bus.failed = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, OTHER, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0, 1'b1,
                      1'b0, 32'h0, 3'b000, "");
        fetch(32'h100, encB(16), 1'b0, 32'h0, 3'b000, "reset_pred");
        rst = 1'b1;

        fetch(32'h100, encB(16), 1'b1, 32'h110, 3'b000, "first_btype");
        applyStimulus(1'b1, 32'h100, encB(16), 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b1,
                      1'b0, 32'h0, 3'b001, "flush_squash");
        repeat (3) exUpdate(1'b0, 32'h100, 3'b000, 1'b0);
        fetch(32'h100, encB(16), 1'b0, 32'h104, 3'b000, "ctr_floor");

        repeat (4) exUpdate(1'b1, 32'h104, 3'b000, 1'b0);
        exUpdate(1'b0, 32'h104, 3'b000, 1'b0);
        exUpdate(1'b0, 32'h1F0, 3'b000, 1'b0);
        exUpdate(1'b0, 32'h1F0, 3'b000, 1'b0);
        fetch(32'h104, encB(16), 1'b1, 32'h114, 3'b000, "ctr_ceiling4");
        exUpdate(1'b1, 32'h104, 3'b000, 1'b0);
        exUpdate(1'b1, 32'h104, 3'b000, 1'b0);
        exUpdate(1'b0, 32'h104, 3'b000, 1'b0);
        exUpdate(1'b0, 32'h1F0, 3'b000, 1'b0);
        exUpdate(1'b0, 32'h1F0, 3'b000, 1'b1);
        fetch(32'h104, encB(16), 1'b1, 32'h114, 3'b000, "ctr_ceiling5");

        applyStimulus(1'b0, 32'h0, OTHER, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b1,
                      1'b0, 32'h0, 3'b000, "");
        fetch(32'h104, encB(16), 1'b1, 32'h114, 3'b000, "spec_b1");
        fetch(32'h108, encB(16), 1'b1, 32'h118, 3'b001, "spec_b2");
        applyStimulus(1'b1, 32'h108, encB(16), 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b1,
                      1'b0, 32'h0, 3'b011, "flush_spec011");
        fetch(32'h300, OTHER, 1'b0, 32'h304, 3'b000, "recovered_hist");

        fetch(32'h104, encB(16), 1'b1, 32'h114, 3'b000, "pre_flush_b");
        applyStimulus(1'b1, 32'h300, OTHER, 1'b1, 1'b1, 1'b1, 32'h1F0, 3'b000, 1'b1, 1'b1,
                      1'b0, 32'h0, 3'b001, "flush_with_ex");
        fetch(32'h300, OTHER, 1'b0, 32'h304, 3'b001, "hist_has_resolved");
        fetch(32'h200, encJ(-8), 1'b1, 32'h1F8, 3'b001, "jal_back");
        fetch(32'h300, OTHER, 1'b0, 32'h304, 3'b001, "jal_no_shift");

        applyStimulus(1'b0, 32'h0, OTHER, 1'b1, 1'b0, 1'b1, 32'h100, 3'b000, 1'b0, 1'b1,
                      1'b0, 32'h0, 3'b000, "");
        applyStimulus(1'b1, 32'h100, encB(16), 1'b1, 1'b1, 1'b0, 32'h100, 3'b001, 1'b0, 1'b0,
                      1'b1, 32'h110, 3'b001, "rdy_low_pred");
        fetch(32'h100, encB(16), 1'b1, 32'h110, 3'b001, "rdy_low_held");
        applyStimulus(1'b0, 32'h0, OTHER, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b1, 1'b1,
                      1'b0, 32'h0, 3'b000, "");
        fetch(32'h300, OTHER, 1'b0, 32'h304, 3'b001, "com_hist_held");

        rst = 1'b0;
        applyStimulus(1'b1, 32'h100, encB(16), 1'b1, 1'b1, 1'b0, 32'h104, 3'b000, 1'b0, 1'b1,
                      1'b0, 32'h0, 3'b001, "midstream_reset");
        rst = 1'b1;
        fetch(32'h100, encB(16), 1'b1, 32'h110, 3'b000, "pht_reinit");
        fetch(32'h10C, encB(-16), 1'b1, 32'h0FC, 3'b001, "btype_negative");
        fetch(32'h110, encB(32'hFFE), 1'b1, 32'h110E, 3'b011, "btype_big_imm");
        fetch(32'h0, encJ(-4), 1'b1, 32'hFFFFFFFC, 3'b111, "jal_wrap");
        fetch(32'h1000, encJ(32'hFFFFE), 1'b1, 32'h100FFE, 3'b111, "jal_big_imm");
        fetch(32'hFFFFFFFC, OTHER, 1'b0, 32'h0, 3'b111, "seq_wrap");

        applyStimulus(1'b1, 32'h100, encB(16), 1'b1, 1'b1, 1'b0, 32'h100, 3'b111, 1'b0, 1'b1,
                      1'b1, 32'h110, 3'b111, "rw_same_entry");
        fetch(32'h100, encB(16), 1'b0, 32'h104, 3'b111, "rw_written");

        repeat (2) applyStimulus(1'b0, 32'h0, OTHER, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000, 1'b0,
                                 1'b1, 1'b0, 32'h0, 3'b000, "");
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
